pcie_txpll_lock_monitor: RTL and testbench
==========================================

# pcie_txpll_lock_monitor

Lock qualifier and lane-reset sequencer directly downstream of the PCIe transmit PLL. It synchronises the PLL's fabric lock indication into a free-running fabric clock domain and requires lock to stay stable for a programmable time. Only then does it release the transceiver lanes and PCIe controller from reset. It also detects lock loss and lock-acquire timeout, and reports both through sticky status flags and a loss counter.

## Interface

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before lane reset release; legal range ≥ 2.
- LANE_RST_HOLD, 64: cycles between LANE_RST_N release and PCIE_READY assertion; legal range ≥ 2.
- TIMEOUT_CYCLES, 1048576: cycles spent in WAIT_LOCK before LOCK_TIMEOUT sets; legal range ≥ 2.

Ports:
- CLK  in  1  free-running fabric clock (init clock). It is not CLK_125, because CLK_125 stops when the PLL is unlocked.
- RESET_N  in  1  reset, synchronous, active-low.
- PLL_LOCK  in  1  fabric lock from the TX PLL; asynchronous to CLK.
- CLR_STATUS  in  1  single-cycle pulse; clears LOCK_LOST, LOCK_TIMEOUT and LOSS_COUNT.
- LANE_RST_N  out  1  active-low reset to the lanes and the PCIe controller.
- PCIE_READY  out  1  high when the PLL is qualified and the lane reset hold has elapsed.
- LOCK_LOST  out  1  sticky; lock dropped after qualification.
- LOCK_TIMEOUT  out  1  sticky; lock was not acquired within TIMEOUT_CYCLES.
- LOSS_COUNT  out  8  count of lock-loss events, saturating at 255.
- STATE  out  2  current state encoding.

## Operation

- PLL_LOCK passes through a 2-flop synchroniser to produce lock_s. This is the only use of PLL_LOCK.
- There is one shared counter, cnt. Its width is ceil(log2(max(LOCK_STABLE_CYCLES, LANE_RST_HOLD, TIMEOUT_CYCLES))).
- States (STATE encoding):
  - WAIT_LOCK = 00
  - STABLE = 01
  - RELEASE = 10
  - RUN = 11
- WAIT_LOCK:
  - If lock_s = 1, go to STABLE with cnt = 0.
  - Otherwise cnt increments. When cnt = TIMEOUT_CYCLES−1, LOCK_TIMEOUT sets, cnt returns to 0, and the block keeps waiting.
- STABLE:
  - If lock_s = 0, go to WAIT_LOCK with cnt = 0. This is not a loss event.
  - Else if cnt = LOCK_STABLE_CYCLES−1, go to RELEASE with cnt = 0.
  - Else cnt increments.
- RELEASE:
  - If lock_s = 0, this is a loss event: go to WAIT_LOCK.
  - Else if cnt = LANE_RST_HOLD−1, go to RUN.
  - Else cnt increments.
- RUN:
  - If lock_s = 0, this is a loss event: go to WAIT_LOCK with cnt = 0.
- Loss event:
  - LOCK_LOST sets.
  - LOSS_COUNT increments, saturating at 255.
- Outputs are registered and decoded from the next state:
  - LANE_RST_N = 1 iff the next state is RELEASE or RUN.
  - PCIE_READY = 1 iff the next state is RUN.
- CLR_STATUS clears LOCK_LOST, LOCK_TIMEOUT and LOSS_COUNT. It does not affect the state machine.
- If CLR_STATUS and a set or increment occur in the same cycle, the set wins:
  - the flag ends at 1;
  - LOSS_COUNT ends at 1.
- Reset, including mid-operation:
  - state = WAIT_LOCK, cnt = 0;
  - LANE_RST_N = 0, PCIE_READY = 0;
  - LOCK_LOST = 0, LOCK_TIMEOUT = 0, LOSS_COUNT = 0, STATE = 00;
  - synchroniser flops = 0.
  - Reset has priority over all other inputs.

## Timing

- Edge 0 is the first CLK edge that captures PLL_LOCK = 1. lock_s is high after edge 1.
- Path from lock to ready:
  - state = STABLE after edge 2;
  - LANE_RST_N = 1 after edge LOCK_STABLE_CYCLES+2 (1026 with defaults);
  - PCIE_READY = 1 after edge LOCK_STABLE_CYCLES+LANE_RST_HOLD+2 (1090 with defaults).
- Lock drop: edge 0 is the first capture of PLL_LOCK = 0. LANE_RST_N = 0, PCIE_READY = 0, LOCK_LOST = 1 and STATE = 00 all take effect after edge 2. This is a 3-cycle worst-case response.
- A PLL_LOCK glitch shorter than one CLK period may be missed or may be seen as a 1-cycle drop. Either outcome is legal. A drop seen in STABLE restarts qualification from zero.
- Timeout: with PLL_LOCK held low from reset release, LOCK_TIMEOUT = 1 after exactly TIMEOUT_CYCLES edges. It then stays set.
- Every output changes only on a CLK rising edge. There is no combinational input-to-output path.

## Test plan

- Reset, then PLL_LOCK rises and stays high: LANE_RST_N rises at edge 1026 and PCIE_READY rises at edge 1090. STATE sequence is 00→01→10→11. LOCK_LOST, LOCK_TIMEOUT and LOSS_COUNT stay 0.
- Qualification interrupted: PLL_LOCK high for 500 cycles, low for 3 cycles, then high again. LANE_RST_N rises only after a fresh 1024-cycle count. LOCK_LOST = 0 and LOSS_COUNT = 0.
- Loss in RUN: drop PLL_LOCK for 10 cycles. PCIE_READY and LANE_RST_N fall 3 edges after the drop. LOCK_LOST = 1 and LOSS_COUNT = 1. Requalification then completes with the same 1026/1090 latencies.
- Timeout with TIMEOUT_CYCLES overridden to 100 and PLL_LOCK held low: LOCK_TIMEOUT = 1 after edge 100. Apply CLR_STATUS: flag reads 0. After 100 more cycles it is 1 again.
- Saturation and clear priority: force 300 loss events, giving LOSS_COUNT = 255. Pulse CLR_STATUS on the same cycle as a loss event: LOSS_COUNT = 1 and LOCK_LOST = 1.
- Reset mid-RELEASE: assert RESET_N = 0 for 1 cycle. All outputs return to their reset values on that edge, and the 1026-cycle qualification restarts.

Source files
------------

// File: rtl/pcie_txpll_lock_monitor.sv
// TX PLL lock qualifier: synchronises PLL_LOCK, requires a stable-lock interval,
// sequences lane reset release and PCIe ready, and tracks lock loss / acquire timeout.
module pcie_txpll_lock_monitor #(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LANE_RST_HOLD      = 64,
   parameter int unsigned TIMEOUT_CYCLES     = 1048576
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       PLL_LOCK,
   input  logic       CLR_STATUS,
   output logic       LANE_RST_N,
   output logic       PCIE_READY,
   output logic       LOCK_LOST,
   output logic       LOCK_TIMEOUT,
   output logic [7:0] LOSS_COUNT,
   output logic [1:0] STATE
);

   localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > LANE_RST_HOLD) ?
                                     LOCK_STABLE_CYCLES : LANE_RST_HOLD;
   localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(LANE_RST_HOLD - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'b00,
      S_STABLE    = 2'b01,
      S_RELEASE   = 2'b10,
      S_RUN       = 2'b11
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             sync_q1;
   logic             lock_s;
   logic             loss_ev;
   logic             timeout_ev;
   logic             lane_rst_n_d;
   logic             pcie_ready_d;
   logic             lock_lost_d;
   logic             lock_timeout_d;
   logic [7:0]       loss_count_d;

   // Two-flop synchroniser; PLL_LOCK is asynchronous to CLK
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         sync_q1 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync_q1 <= PLL_LOCK;
         lock_s  <= sync_q1;
      end
   end

   // State and shared counter registers
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= S_WAIT_LOCK;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and event decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      loss_ev    = 1'b0;
      timeout_ev = 1'b0;
      case (state_q)
         S_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               timeout_ev = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STABLE: begin
            // A drop before qualification just restarts the wait, no loss recorded
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RELEASE: begin
            if (!lock_s) begin
               loss_ev = 1'b1;
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               loss_ev = 1'b1;
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // Lane controls decoded from the next state so they line up with STATE
   always_comb begin
      lane_rst_n_d = 1'b0;
      pcie_ready_d = 1'b0;
      if ((state_d == S_RELEASE) || (state_d == S_RUN)) begin
         lane_rst_n_d = 1'b1;
      end
      if (state_d == S_RUN) begin
         pcie_ready_d = 1'b1;
      end
   end

   // Sticky status: clear first so a same-cycle set or increment wins
   always_comb begin
      lock_lost_d    = LOCK_LOST;
      lock_timeout_d = LOCK_TIMEOUT;
      loss_count_d   = LOSS_COUNT;
      if (CLR_STATUS) begin
         lock_lost_d    = 1'b0;
         lock_timeout_d = 1'b0;
         loss_count_d   = 8'd0;
      end
      if (loss_ev) begin
         lock_lost_d = 1'b1;
         if (loss_count_d != 8'hFF) begin
            loss_count_d = loss_count_d + 8'd1;
         end
      end
      if (timeout_ev) begin
         lock_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         LANE_RST_N   <= 1'b0;
         PCIE_READY   <= 1'b0;
         LOCK_LOST    <= 1'b0;
         LOCK_TIMEOUT <= 1'b0;
         LOSS_COUNT   <= 8'd0;
      end else begin
         LANE_RST_N   <= lane_rst_n_d;
         PCIE_READY   <= pcie_ready_d;
         LOCK_LOST    <= lock_lost_d;
         LOCK_TIMEOUT <= lock_timeout_d;
         LOSS_COUNT   <= loss_count_d;
      end
   end

   assign STATE = state_q;

endmodule

// File: tb/tb_pcie_txpll_lock_monitor.sv
// Self-checking bench for pcie_txpll_lock_monitor: run-length reference model
// compared every cycle, plus directed latency / saturation / reset checks.
module tb_pcie_txpll_lock_monitor;

   localparam int unsigned LS   = 20;
   localparam int unsigned HOLD = 6;
   localparam int unsigned TO   = 100;
   localparam int          CAP  = LS + HOLD + 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       clr;
   logic       lane_rst_n;
   logic       pcie_ready;
   logic       lock_lost;
   logic       lock_timeout;
   logic [7:0] loss_count;
   logic [1:0] state;

   always #5 clk = ~clk;

   pcie_txpll_lock_monitor #(
      .LOCK_STABLE_CYCLES(LS),
      .LANE_RST_HOLD     (HOLD),
      .TIMEOUT_CYCLES    (TO)
   ) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .PLL_LOCK    (pll_lock),
      .CLR_STATUS  (clr),
      .LANE_RST_N  (lane_rst_n),
      .PCIE_READY  (pcie_ready),
      .LOCK_LOST   (lock_lost),
      .LOCK_TIMEOUT(lock_timeout),
      .LOSS_COUNT  (loss_count),
      .STATE       (state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: m_r = consecutive qualified-lock cycles seen by the sequencer,
   // m_z = consecutive unlocked cycles counted while waiting for lock.
   int m_s1 = 0, m_s2 = 0, m_r = 0, m_z = 0;
   int m_lost = 0, m_to = 0, m_cnt = 0;

   always @(posedge clk) begin
      int  ls;
      bit  loss;
      bit  tev;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_r = 0; m_z = 0;
         m_lost = 0; m_to = 0; m_cnt = 0;
      end else begin
         ls   = m_s2;
         loss = 1'b0;
         tev  = 1'b0;
         if (ls != 0) begin
            if (m_r < CAP) m_r++;
         end else if (m_r > 0) begin
            loss = (m_r > LS);
            m_r  = 0;
            m_z  = 0;
         end else begin
            m_z++;
            if (m_z == TO) begin
               tev = 1'b1;
               m_z = 0;
            end
         end
         if (clr) begin
            m_lost = 0; m_to = 0; m_cnt = 0;
         end
         if (loss) begin
            m_lost = 1;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
         end
         if (tev) m_to = 1;
         m_s2 = m_s1;
         m_s1 = (pll_lock === 1'b1) ? 1 : 0;
      end
   end

   int exp_st;
   always @(posedge clk) begin
      #1;
      exp_st = (m_r == 0) ? 0 : (m_r <= LS) ? 1 : (m_r <= LS + HOLD) ? 2 : 3;
      check("state",        32'(state),        exp_st);
      check("lane_rst_n",   32'(lane_rst_n),   (exp_st >= 2) ? 1 : 0);
      check("pcie_ready",   32'(pcie_ready),   (exp_st == 3) ? 1 : 0);
      check("lock_lost",    32'(lock_lost),    m_lost);
      check("lock_timeout", 32'(lock_timeout), m_to);
      check("loss_count",   32'(loss_count),   m_cnt);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Call right after raising pll_lock at a negedge; e=0 is the capture edge
   task automatic measure_rise(output int lane_e, output int ready_e);
      lane_e  = -1;
      ready_e = -1;
      for (int e = 0; e < LS + HOLD + 20; e++) begin
         tick(1);
         if (lane_e < 0 && lane_rst_n === 1'b1) lane_e = e;
         if (ready_e < 0 && pcie_ready === 1'b1) ready_e = e;
      end
   endtask

   task automatic drop_for(input int n, output int fall_e);
      pll_lock = 1'b0;
      fall_e   = -1;
      for (int e = 0; e < n; e++) begin
         tick(1);
         if (fall_e < 0 && lane_rst_n === 1'b0 && pcie_ready === 1'b0) fall_e = e;
      end
   endtask

   task automatic wait_ready(input string name);
      int k;
      k = 0;
      while (pcie_ready !== 1'b1 && k < 200) begin
         tick(1);
         k++;
      end
      check(name, 32'(pcie_ready), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lane_e, ready_e, fall_e, k, len;
      rst_n = 1'b0; pll_lock = 1'b0; clr = 1'b0;
      tick(3);
      check("rst_lane",  32'(lane_rst_n),   0);
      check("rst_ready", 32'(pcie_ready),   0);
      check("rst_lost",  32'(lock_lost),    0);
      check("rst_to",    32'(lock_timeout), 0);
      check("rst_cnt",   32'(loss_count),   0);
      check("rst_state", 32'(state),        0);

      // Timeout with lock held low from reset release
      rst_n = 1'b1;
      tick(99);
      check("to_edge99",  32'(lock_timeout), 0);
      tick(1);
      check("to_edge100", 32'(lock_timeout), 1);
      clr = 1'b1; tick(1); clr = 1'b0;
      check("to_cleared", 32'(lock_timeout), 0);
      tick(98);
      check("to_edge199", 32'(lock_timeout), 0);
      tick(1);
      check("to_edge200", 32'(lock_timeout), 1);

      // Clean acquisition
      pll_lock = 1'b1;
      measure_rise(lane_e, ready_e);
      check("acq_lane_edge",  lane_e,  22);
      check("acq_ready_edge", ready_e, 28);
      check("acq_state_run",  32'(state), 3);
      check("acq_no_loss",    32'(loss_count), 0);

      // Loss in RUN and requalification
      drop_for(10, fall_e);
      check("loss_fall_edge", fall_e, 2);
      check("loss_lost",      32'(lock_lost),  1);
      check("loss_cnt",       32'(loss_count), 1);
      pll_lock = 1'b1;
      measure_rise(lane_e, ready_e);
      check("requal_lane_edge",  lane_e,  22);
      check("requal_ready_edge", ready_e, 28);

      // Interrupted qualification is not a loss and restarts the count
      drop_for(10, fall_e);
      clr = 1'b1; tick(1); clr = 1'b0;
      check("clr_cnt",  32'(loss_count), 0);
      check("clr_lost", 32'(lock_lost),  0);
      pll_lock = 1'b1; tick(10);
      pll_lock = 1'b0; tick(3);
      pll_lock = 1'b1;
      measure_rise(lane_e, ready_e);
      check("intr_lane_edge",  lane_e,  22);
      check("intr_ready_edge", ready_e, 28);
      check("intr_cnt",        32'(loss_count), 0);
      check("intr_lost",       32'(lock_lost),  0);

      // Reset mid-RELEASE
      drop_for(6, fall_e);
      pll_lock = 1'b1;
      k = 0;
      while (lane_rst_n !== 1'b1 && k < 60) begin
         tick(1);
         k++;
      end
      check("mid_reach_release", 32'(lane_rst_n), 1);
      tick(2);
      check("mid_in_release", 32'(state), 2);
      rst_n = 1'b0; tick(1);
      check("mid_rst_lane",  32'(lane_rst_n),   0);
      check("mid_rst_ready", 32'(pcie_ready),   0);
      check("mid_rst_state", 32'(state),        0);
      check("mid_rst_cnt",   32'(loss_count),   0);
      check("mid_rst_lost",  32'(lock_lost),    0);
      check("mid_rst_to",    32'(lock_timeout), 0);
      rst_n = 1'b1;
      measure_rise(lane_e, ready_e);
      check("mid_lane_edge",  lane_e,  22);
      check("mid_ready_edge", ready_e, 28);

      // 300 loss events saturate the counter
      for (int i = 0; i < 300; i++) begin
         pll_lock = 1'b0;
         tick(int'($urandom_range(1, 4)));
         pll_lock = 1'b1;
         tick(LS + 1 + int'($urandom_range(0, HOLD + 4)));
      end
      check("sat_cnt",  32'(loss_count), 255);
      check("sat_lost", 32'(lock_lost),  1);

      // Clear coinciding with a loss event: the increment wins
      wait_ready("sat_ready");
      pll_lock = 1'b0;
      tick(2);
      clr = 1'b1; tick(1); clr = 1'b0;
      check("clr_loss_cnt",  32'(loss_count), 1);
      check("clr_loss_lost", 32'(lock_lost),  1);

      // Random lock activity with sporadic clears and resets
      for (int s = 0; s < 150; s++) begin
         pll_lock = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(90, 130))
                                            : int'($urandom_range(1, 40));
         for (int c = 0; c < len; c++) begin
            clr   = ($urandom_range(0, 30) == 0);
            rst_n = ($urandom_range(0, 400) != 0);
            tick(1);
         end
      end
      clr = 1'b0; rst_n = 1'b1;
      tick(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
